// File: rtl/ik_joint_update_if.sv
// rtl/ik_joint_update_if.sv - solver-side handshake bundle for the IK joint update controller
interface ik_joint_update_if #(
  parameter int N_JOINTS = 6,
  parameter int W        = 36
);
  logic                       solve_req;
  logic                       delta_ready;
  logic                       delta_valid;
  logic [N_JOINTS*W-1:0]      delta;
  logic [N_JOINTS*4*W-1:0]    dh_param;

  modport master (
    output solve_req, delta_ready, dh_param,
    input  delta_valid, delta
  );

  modport slave (
    input  solve_req, delta_ready, dh_param,
    output delta_valid, delta
  );
endinterface

// File: rtl/ik_joint_update.sv
// rtl/ik_joint_update.sv - IK iteration controller: applies solver deltas to DH params until converged
// Optional: define IK_ANGLE_WRAP_EN to wrap revolute theta into [-PI, PI) before saturation.
module ik_joint_update #(
  parameter int N_JOINTS = 6,
  parameter int W        = 36,
  parameter int ITER_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start,
  input  logic [N_JOINTS-1:0]        joint_type,
  input  logic [N_JOINTS*4*W-1:0]    dh_init,
  input  logic [W-1:0]               tol,
  input  logic [ITER_W-1:0]          max_iter,
  ik_joint_update_if.master          solver,
  output logic [ITER_W-1:0]          iter_count,
  output logic                       busy,
  output logic                       done,
  output logic                       converged
);

  localparam int JW = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_APPLY = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic signed [W:0] SAT_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SAT_MIN = {2'b11, {(W-1){1'b0}}};
  localparam logic [W-1:0]      DELTA_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]      ABS_MAX   = {1'b0, {(W-1){1'b1}}};
`ifdef IK_ANGLE_WRAP_EN
  localparam logic signed [W:0] PI_Q     = (W+1)'(823550);
  localparam logic signed [W:0] TWO_PI_Q = (W+1)'(1647099);
`endif

  logic [2:0]                 state;
  logic [JW-1:0]              jidx;
  logic [W-1:0]               maxabs;
  logic [N_JOINTS*W-1:0]      delta_q;
  logic [N_JOINTS*4*W-1:0]    dh_q;

  int                         pos;
  logic [W-1:0]               cur_val;
  logic [W-1:0]               cur_delta;
  logic [W-1:0]               abs_delta;
  logic signed [W:0]          sum;
  logic signed [W:0]          adj;
  logic [W-1:0]               sat_val;
  logic [ITER_W-1:0]          iter_next;
  logic [ITER_W-1:0]          iter_limit;

  assign solver.solve_req   = en && (state == S_REQ);
  assign solver.delta_ready = en && (state == S_WAIT);
  assign solver.dh_param    = dh_q;
  assign busy               = (state == S_LOAD) || (state == S_REQ) || (state == S_WAIT) ||
                              (state == S_APPLY) || (state == S_CHECK);
  assign done               = (state == S_DONE);

  // Revolute joints update theta (field 0), prismatic joints update d (field 1).
  always_comb begin
    pos       = (int'(jidx) * 4 + (joint_type[jidx] ? 0 : 1)) * W;
    cur_val   = dh_q[pos +: W];
    cur_delta = delta_q[int'(jidx) * W +: W];
    sum       = $signed({cur_val[W-1], cur_val}) + $signed({cur_delta[W-1], cur_delta});
    adj       = sum;
`ifdef IK_ANGLE_WRAP_EN
    if (joint_type[jidx]) begin
      if (sum >= PI_Q)
        adj = sum - TWO_PI_Q;
      else if (sum < -PI_Q)
        adj = sum + TWO_PI_Q;
    end
`endif
    if (adj > SAT_MAX)
      sat_val = SAT_MAX[W-1:0];
    else if (adj < SAT_MIN)
      sat_val = SAT_MIN[W-1:0];
    else
      sat_val = adj[W-1:0];

    if (cur_delta == DELTA_MIN)
      abs_delta = ABS_MAX;
    else if (cur_delta[W-1])
      abs_delta = -cur_delta;
    else
      abs_delta = cur_delta;

    iter_next  = iter_count + 1'b1;
    iter_limit = (max_iter == '0) ? ITER_W'(1) : max_iter;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      jidx       <= '0;
      maxabs     <= '0;
      delta_q    <= '0;
      dh_q       <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start)
            state <= S_LOAD;
        end
        S_LOAD: begin
          dh_q       <= dh_init;
          iter_count <= '0;
          maxabs     <= '0;
          converged  <= 1'b0;
          jidx       <= '0;
          state      <= S_REQ;
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (solver.delta_valid) begin
            delta_q <= solver.delta;
            jidx    <= '0;
            state   <= S_APPLY;
          end
        end
        S_APPLY: begin
          dh_q[pos +: W] <= sat_val;
          if (abs_delta > maxabs)
            maxabs <= abs_delta;
          if (jidx == JW'(N_JOINTS - 1))
            state <= S_CHECK;
          else
            jidx <= jidx + 1'b1;
        end
        S_CHECK: begin
          iter_count <= iter_next;
          if (maxabs <= tol) begin
            converged <= 1'b1;
            state     <= S_DONE;
          end else if (iter_next >= iter_limit) begin
            converged <= 1'b0;
            state     <= S_DONE;
          end else begin
            maxabs <= '0;
            state  <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
